// File: rtl/noc_link_pkg.sv
// ============================================================================
// noc_link_pkg : link-state encodings and default NoC link sizing
// Rev 1.0
// ============================================================================
`default_nettype none

package noc_link_pkg;

  typedef enum logic [1:0] {
    LINK_STOP  = 2'd0,
    LINK_ACT   = 2'd1,
    LINK_RUN   = 2'd2,
    LINK_DEACT = 2'd3
  } link_state_e;

  // Shared with link_credit_rx so both ends agree on sizing.
  localparam int NOC_FLIT_WIDTH = 128;
  localparam int NOC_CRD_MAX    = 15;

endpackage

`default_nettype wire

// File: rtl/link_crd_counter.sv
// ============================================================================
// link_crd_counter : saturating credit counter with sticky overflow flag
// Rev 1.0
// ============================================================================
`default_nettype none

module link_crd_counter
  import noc_link_pkg::*;
#(
  parameter  int CRD_MAX = NOC_CRD_MAX,
  localparam int CRD_W   = $clog2(CRD_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec,
  input  logic             inc,
  input  logic             clr,
  output logic [CRD_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CRD_W-1:0] c_crd_max = CRD_W'(CRD_MAX);

  logic w_inc_only;
  logic w_dec_only;

  assign w_inc_only = inc & ~dec;
  assign w_dec_only = dec & ~inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (clr) begin
        cnt <= '0;
      end else if (w_inc_only) begin
        if (cnt != c_crd_max) cnt <= cnt + CRD_W'(1);
      end else if (w_dec_only) begin
        cnt <= cnt - CRD_W'(1);
      end
      // Overflow is flagged even if the counter is being cleared this cycle.
      if (w_inc_only && (cnt == c_crd_max)) ovf <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/link_credit_tx.sv
// ============================================================================
// link_credit_tx : credit-based NoC link transmitter with req/ack bring-up FSM
// Optional: LINK_CREDIT_TX_PERF_EN adds the stall_cnt output.   Rev 1.0
// ============================================================================
`default_nettype none

module link_credit_tx
  import noc_link_pkg::*;
#(
  parameter  int FLIT_WIDTH = NOC_FLIT_WIDTH,
  parameter  int CRD_MAX    = NOC_CRD_MAX,
  localparam int CRD_W      = $clog2(CRD_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  link_en,
  input  logic                  fifo_empty,
  input  logic [FLIT_WIDTH-1:0] fifo_data,
  output logic                  fifo_pop,
  output logic                  tx_flitv,
  output logic [FLIT_WIDTH-1:0] tx_flit,
  input  logic                  tx_lcrdv,
  output logic                  tx_link_req,
  input  logic                  tx_link_ack,
  output logic [1:0]            link_state,
  output logic [CRD_W-1:0]      crd_cnt,
  output logic                  crd_ovf
`ifdef LINK_CREDIT_TX_PERF_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  link_state_e r_state;
  link_state_e w_state_next;
  logic        w_send;
  logic        w_crd_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LINK_STOP;
    else        r_state <= w_state_next;
  end

  // Abort (link_en low) takes priority over ack while activating.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LINK_STOP:  if (link_en) w_state_next = LINK_ACT;
      LINK_ACT: begin
        if (!link_en)         w_state_next = LINK_DEACT;
        else if (tx_link_ack) w_state_next = LINK_RUN;
      end
      LINK_RUN:   if (!link_en) w_state_next = LINK_DEACT;
      LINK_DEACT: if (!tx_link_ack) w_state_next = LINK_STOP;
      default:    w_state_next = LINK_STOP;
    endcase
  end

  assign w_send     = (r_state == LINK_RUN) & ~fifo_empty & (crd_cnt != '0);
  assign fifo_pop   = w_send;
  assign link_state = r_state;
  assign w_crd_clr  = (r_state == LINK_STOP) | (w_state_next == LINK_STOP);

  link_crd_counter #(
    .CRD_MAX (CRD_MAX)
  ) u_crd (
    .clk   (clk),
    .rst_n (rst_n),
    .dec   (w_send),
    .inc   (tx_lcrdv & (r_state != LINK_STOP)),
    .clr   (w_crd_clr),
    .cnt   (crd_cnt),
    .ovf   (crd_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_flitv    <= 1'b0;
      tx_flit     <= '0;
      tx_link_req <= 1'b0;
    end else begin
      tx_flitv    <= w_send;
      if (w_send) tx_flit <= fifo_data;
      tx_link_req <= (w_state_next == LINK_ACT) | (w_state_next == LINK_RUN);
    end
  end

`ifdef LINK_CREDIT_TX_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (w_state_next == LINK_STOP) begin
      stall_cnt <= '0;
    end else if ((r_state == LINK_RUN) && !fifo_empty && (crd_cnt == '0)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_link_credit_tx.sv
// ============================================================================
// tb_link_credit_tx : directed + randomized bench against a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_link_credit_tx;

  localparam int FW   = 128;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          link_en;
  logic          fifo_empty;
  logic [FW-1:0] fifo_data;
  logic          fifo_pop;
  logic          tx_flitv;
  logic [FW-1:0] tx_flit;
  logic          tx_lcrdv;
  logic          tx_link_req;
  logic          tx_link_ack;
  logic [1:0]    link_state;
  logic [3:0]    crd_cnt;
  logic          crd_ovf;
`ifdef LINK_CREDIT_TX_PERF_EN
  logic [31:0]   stall_cnt;
`endif

  link_credit_tx #(.FLIT_WIDTH(FW), .CRD_MAX(CMAX)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .link_en     (link_en),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_pop    (fifo_pop),
    .tx_flitv    (tx_flitv),
    .tx_flit     (tx_flit),
    .tx_lcrdv    (tx_lcrdv),
    .tx_link_req (tx_link_req),
    .tx_link_ack (tx_link_ack),
    .link_state  (link_state),
    .crd_cnt     (crd_cnt),
    .crd_ovf     (crd_ovf)
`ifdef LINK_CREDIT_TX_PERF_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: the FIFO is a queue; link state is plain integers.
  logic [FW-1:0] q[$];
  int            m_state;
  int            m_crd;
  bit            m_ovf;
  bit            m_flitv;
  logic [FW-1:0] m_flit;
  bit            m_req;
  longint        m_stall;
  bit            ak;

  function automatic void chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_state = 0; m_crd = 0; m_ovf = 0; m_flitv = 0; m_flit = '0; m_req = 0; m_stall = 0;
  endtask

  task automatic drive_fifo();
    fifo_empty = (q.size() == 0);
    fifo_data  = (q.size() != 0) ? q[0] : {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic push(input logic [FW-1:0] d);
    q.push_back(d);
    drive_fifo();
  endtask

  task automatic step(input bit en, input bit cr, input bit ack_in);
    bit send, novf;
    int ns, nc;
    longint nst;
    link_en = en; tx_lcrdv = cr; tx_link_ack = ack_in;
    drive_fifo();
    @(negedge clk);
    send = (m_state == 2) && (q.size() != 0) && (m_crd != 0);
    chk("fifo_pop",    fifo_pop,    send);
    chk("tx_flitv",    tx_flitv,    m_flitv);
    chk("tx_flit",     tx_flit,     m_flit);
    chk("link_state",  link_state,  m_state);
    chk("tx_link_req", tx_link_req, m_req);
    chk("crd_cnt",     crd_cnt,     m_crd);
    chk("crd_ovf",     crd_ovf,     m_ovf);
`ifdef LINK_CREDIT_TX_PERF_EN
    chk("stall_cnt",   stall_cnt,   m_stall);
`endif
    case (m_state)
      0:       ns = en ? 1 : 0;
      1:       ns = !en ? 3 : (ack_in ? 2 : 1);
      2:       ns = en ? 2 : 3;
      default: ns = ack_in ? 3 : 0;
    endcase
    novf = m_ovf;
    if (m_state != 0 && cr && !send && m_crd == CMAX) novf = 1;
    if (m_state == 0 || ns == 0) nc = 0;
    else begin
      nc = m_crd - int'(send) + int'(cr);
      if (nc > CMAX) nc = CMAX;
    end
    if (ns == 0) nst = 0;
    else if (m_state == 2 && q.size() != 0 && m_crd == 0) nst = (m_stall + 1) % 64'h1_0000_0000;
    else nst = m_stall;
    @(posedge clk);
    #1;
    m_flitv = send;
    if (send) m_flit = q.pop_front();
    m_state = ns; m_crd = nc; m_ovf = novf; m_req = (ns == 1 || ns == 2); m_stall = nst;
    drive_fifo();
  endtask

  initial begin
    bit reached;
    rst_n = 1'b0; link_en = 0; tx_lcrdv = 0; tx_link_ack = 0;
    model_reset();
    drive_fifo();
    #22;
    chk("rst_state", link_state, 0);
    chk("rst_crd",   crd_cnt,    0);
    chk("rst_flitv", tx_flitv,   0);
    chk("rst_flit",  tx_flit,    0);
    chk("rst_req",   tx_link_req, 0);
    chk("rst_ovf",   crd_ovf,    0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Bring-up with ack three cycles after link_en
    step(1, 0, 0);
    chk("t1_act_state", link_state, 1);
    chk("t1_act_req",   tx_link_req, 1);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 1);
    chk("t1_run_state", link_state, 2);
    chk("t1_run_crd",   crd_cnt, 0);

    // Four credits, six flits queued
    for (int i = 0; i < 4; i++) step(1, 1, 1);
    chk("t2_crd4", crd_cnt, 4);
    for (int i = 0; i < 6; i++) push(FW'('hA0 + i));
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 1);
      chk("t2_flitv", tx_flitv, (i < 4) ? 1'b1 : 1'b0);
      if (i < 4) chk("t2_flit", tx_flit, FW'('hA0 + i));
    end
    chk("t2_crd0", crd_cnt, 0);
`ifdef LINK_CREDIT_TX_PERF_EN
    chk("t2_stall", stall_cnt, 2);
`endif

    // Same-cycle credit return does not enable a send; with credit it nets out
    step(1, 1, 1);
    chk("t3_nosend", tx_flitv, 0);
    chk("t3_crd1",   crd_cnt,  1);
    step(1, 1, 1);
    chk("t3_send",   tx_flitv, 1);
    chk("t3_flit",   tx_flit,  FW'('hA4));
    chk("t3_crd_keep", crd_cnt, 1);

    // Saturation and sticky overflow
    step(1, 0, 1);
    chk("t4_drain", crd_cnt, 0);
    for (int i = 0; i < 15; i++) step(1, 1, 1);
    chk("t4_crd15", crd_cnt, 15);
    chk("t4_noovf", crd_ovf, 0);
    step(1, 1, 1);
    chk("t4_sat", crd_cnt, 15);
    chk("t4_ovf", crd_ovf, 1);
    step(1, 0, 1);
    chk("t4_ovf_sticky", crd_ovf, 1);

    // Tear-down while sending
    for (int i = 0; i < 3; i++) push(FW'('hB0 + i));
    step(0, 0, 1);
    chk("t5_flitv", tx_flitv, 1);
    chk("t5_flit",  tx_flit,  FW'('hB0));
    chk("t5_state", link_state, 3);
    chk("t5_req",   tx_link_req, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("t5_stop",  link_state, 0);
    chk("t5_crd0",  crd_cnt, 0);

    // Randomized traffic
    ak = 0;
    for (int c = 0; c < 3000; c++) begin
      if (q.size() < 8 && ($urandom % 3 == 0)) push({$urandom, $urandom, $urandom, $urandom});
      if ($urandom % 60 == 0) link_en = ~link_en;
      if (m_req) ak = ($urandom % 3 != 0) ? 1'b1 : ak;
      else       ak = ($urandom % 3 == 0) ? 1'b0 : ak;
      step(link_en, ($urandom % 5) < 2, ak);
    end

    // Async reset while a flit is on the link
    reached = 0;
    for (int c = 0; c < 200 && !reached; c++) begin
      if (q.size() < 2) push({$urandom, $urandom, $urandom, $urandom});
      step(1, 1, m_req);
      reached = (m_state == 2) && m_flitv;
    end
    chk("t6_reach_run_flitv", reached, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_flitv", tx_flitv,   0);
    chk("t6_state", link_state, 0);
    chk("t6_crd",   crd_cnt,    0);
    chk("t6_req",   tx_link_req, 0);
    model_reset();
    #2 rst_n = 1'b1;
    for (int c = 0; c < 40; c++) step(1, $urandom % 2, m_req);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
